// File: rtl/exp_adc_pkg.sv
// Shared constants, frame field positions and FSM state type for the
// multi-lane ADC SPI responder.
package exp_adc_pkg;

    localparam int REG_FRAME_BITS = 24;
    localparam int REG_CMD_BITS   = 8;
    localparam int REG_HDR_BITS   = 16;
    localparam int REG_ADDR_W     = 15;

    localparam logic [REG_CMD_BITS-1:0] REG_ENTRY_CMD = 8'hA0;
    localparam logic [REG_ADDR_W-1:0]   REG_EXIT_ADDR = 15'h0014;

    localparam int REG_RW_BIT   = 23;
    localparam int REG_ADDR_MSB = 22;
    localparam int REG_ADDR_LSB = 8;
    localparam int REG_DATA_MSB = 7;
    localparam int REG_DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        REG  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for a group of asynchronous pins, with registered
// rise/fall strobes derived from the synchronized levels.
module spi_pin_sync #(
    parameter int           N       = 1,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [N-1:0] pin,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] meta_q, sync_q, prev_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise   <= '0;
            fall   <= '0;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
            fall   <= ~sync_q & prev_q;
        end
    end

    assign level = sync_q;

endmodule

// File: rtl/exp_adc_spi_responder.sv
// SPI responder emulating a multi-lane ADC: streams AXIS samples out on
// NUM_SDI lanes and serves the 24-bit register-access protocol.
module exp_adc_spi_responder
    import exp_adc_pkg::*;
#(
    parameter int NUM_SDI    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int REG_DEPTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    input  logic                  spi_sdi,
    output logic [NUM_SDI-1:0]    spi_sdo,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  conv_mode,
    output logic                  underrun
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] w);
        return (w << NUM_SDI) | (w >> (DATA_WIDTH - NUM_SDI));
    endfunction

    function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
        return int'(a) < REG_DEPTH;
    endfunction

    logic [2:0] pin_lvl, pin_rise, pin_fall;
    logic       sck_rise, csn_fall, csn_rise, sdi_s, unused_pins;

    // csn idles high, so its synchronizer resets high to avoid a false edge
    spi_pin_sync #(.N(3), .RST_VAL(3'b010)) u_pin_sync (
        .clk_in (aclk),
        .rst_n  (aresetn),
        .pin    ({spi_sdi, spi_csn, spi_sck}),
        .level  (pin_lvl),
        .rise   (pin_rise),
        .fall   (pin_fall)
    );

    assign sck_rise    = pin_rise[0];
    assign csn_fall    = pin_fall[1];
    assign csn_rise    = pin_rise[1];
    assign sdi_s       = pin_lvl[2];
    assign unused_pins = ^{pin_lvl[1:0], pin_rise[2], pin_fall[2], pin_fall[0]};

    spi_state_t state_q, state_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csn_rise)      state_d = IDLE;
        else if (csn_fall) state_d = conv_mode ? CONV : REG;
    end

    logic [DATA_WIDTH-1:0] smp_q, last_q, rot_q, word_sel;
    logic                  smp_full, rst_done, frame_start;

    assign s_axis_tready = rst_done & ~smp_full;
    assign frame_start   = csn_fall & conv_mode;
    assign word_sel      = smp_full ? smp_q : last_q;

    // Sample buffer and conversion word rotator; the word rotates by one lane group per SCK
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done <= 1'b0;
            smp_full <= 1'b0;
            smp_q    <= '0;
            last_q   <= '0;
            rot_q    <= '0;
            underrun <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            underrun <= 1'b0;
            if (frame_start) begin
                smp_full <= 1'b0;
                last_q   <= word_sel;
                rot_q    <= rotl(word_sel);
                underrun <= ~smp_full;
            end else if (s_axis_tvalid && s_axis_tready) begin
                smp_q    <= s_axis_tdata;
                smp_full <= 1'b1;
            end
            if (sck_rise && state_q == CONV) rot_q <= rotl(rot_q);
        end
    end

    logic [REG_FRAME_BITS-1:0] sr_q, sr_next;
    logic [4:0]                cnt_q;
    logic                      entry_q, hdr_rw, cm_rw, commit;
    logic [7:0]                rd_q, rd_val, cm_data;
    logic [REG_ADDR_W-1:0]     hdr_addr, cm_addr;
    logic [7:0]                regs [REG_DEPTH];

    assign sr_next  = {sr_q[REG_FRAME_BITS-2:0], sdi_s};
    assign hdr_rw   = sr_next[REG_ADDR_W];
    assign hdr_addr = sr_next[REG_ADDR_W-1:0];
    assign rd_val   = in_range(hdr_addr) ? regs[hdr_addr[AW-1:0]] : 8'h00;
    assign cm_rw    = sr_q[REG_RW_BIT];
    assign cm_addr  = sr_q[REG_ADDR_MSB:REG_ADDR_LSB];
    assign cm_data  = sr_q[REG_DATA_MSB:REG_DATA_LSB];
    assign commit   = csn_rise && state_q == REG && !cm_rw &&
                      cnt_q == 5'(REG_FRAME_BITS);

    // Frame shifter, mode control and SDO lanes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            entry_q   <= 1'b0;
            rd_q      <= '0;
            spi_sdo   <= '0;
            conv_mode <= 1'b1;
        end else if (csn_rise) begin
            if (state_q == CONV && entry_q) conv_mode <= 1'b0;
            if (commit && cm_addr == REG_EXIT_ADDR && cm_data[0]) conv_mode <= 1'b1;
            sr_q    <= '0;
            cnt_q   <= '0;
            entry_q <= 1'b0;
            rd_q    <= '0;
            spi_sdo <= '0;
        end else if (csn_fall) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            entry_q <= 1'b0;
            rd_q    <= '0;
            spi_sdo <= conv_mode ? word_sel[DATA_WIDTH-1 -: NUM_SDI] : '0;
        end else if (sck_rise && state_q != IDLE) begin
            sr_q <= sr_next;
            if (cnt_q != '1) cnt_q <= cnt_q + 5'd1;
            if (state_q == CONV) begin
                spi_sdo <= rot_q[DATA_WIDTH-1 -: NUM_SDI];
                if (cnt_q == 5'(REG_CMD_BITS - 1) &&
                    sr_next[REG_CMD_BITS-1:0] == REG_ENTRY_CMD)
                    entry_q <= 1'b1;
            end else if (cnt_q == 5'(REG_HDR_BITS - 1)) begin
                // Header complete: latch the read byte and present its MSB
                rd_q    <= hdr_rw ? rd_val : 8'h00;
                spi_sdo <= NUM_SDI'(hdr_rw & rd_val[7]);
            end else begin
                rd_q    <= rd_q << 1;
                spi_sdo <= NUM_SDI'(rd_q[6]);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else if (commit && in_range(cm_addr)) begin
            regs[cm_addr[AW-1:0]] <= cm_data;
        end
    end

endmodule

// File: tb/tb_exp_adc_spi_responder.sv
// Randomized self-checking bench for exp_adc_spi_responder against a
// frame-level behavioural model of the emulated ADC.
module tb_exp_adc_spi_responder;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int G  = DW / N;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          spi_sck, spi_csn, spi_sdi;
    logic [N-1:0]  spi_sdo;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic          conv_mode, underrun;

    exp_adc_spi_responder #(.NUM_SDI(N), .DATA_WIDTH(DW), .REG_DEPTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .spi_sck       (spi_sck),
        .spi_csn       (spi_csn),
        .spi_sdi       (spi_sdi),
        .spi_sdo       (spi_sdo),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .conv_mode     (conv_mode),
        .underrun      (underrun)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_under = 0;

    always @(posedge aclk) if (underrun === 1'b1) n_under++;

    // Reference model state
    logic [DW-1:0] m_buf, m_last;
    bit            m_full, m_conv;
    logic [7:0]    m_regs [0:31];
    int            m_under;

    logic [N-1:0]  capt [0:63];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_buf = '0; m_last = '0; m_full = 0; m_conv = 1;
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    endtask

    task automatic spi_frame(input int nbits, input logic [23:0] tx, input bit rst_mid);
        spi_csn = 1'b0;
        repeat (8) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = (i < 24) ? tx[23-i] : 1'b0;
            repeat (8) @(negedge aclk);
            capt[i] = spi_sdo;
            spi_sck = 1'b1;
            repeat (8) @(negedge aclk);
            spi_sck = 1'b0;
        end
        if (rst_mid) begin
            aresetn = 1'b0;
            repeat (3) @(negedge aclk);
        end
        repeat (8) @(negedge aclk);
        spi_csn = 1'b1;
        spi_sdi = 1'b0;
        repeat (8) @(negedge aclk);
        aresetn = 1'b1;
        repeat (8) @(negedge aclk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("push_ready_wait", 64'(t < 50), 64'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        m_buf  = d;
        m_full = 1;
        chk("tready_full", s_axis_tready, 1'b0);
    endtask

    task automatic conv_frame(input int nbits, input logic [23:0] tx, input string tag);
        logic [DW-1:0] w;
        if (m_full) begin
            w = m_buf; m_last = m_buf; m_full = 0;
        end else begin
            w = m_last; m_under++;
        end
        spi_frame(nbits, tx, 0);
        for (int i = 0; i < nbits; i++)
            chk(tag, 64'(capt[i]), 64'((w >> (DW - ((i % G) + 1) * N)) & 32'd3));
        chk("underrun_count", n_under, m_under);
        if (nbits >= 8 && tx[23:16] == 8'hA0) m_conv = 0;
        chk("conv_mode_after_conv", conv_mode, m_conv);
        chk("tready_after_conv", s_axis_tready, 1'b1);
    endtask

    task automatic reg_frame(input int nbits, input bit rw, input logic [14:0] addr,
                             input logic [7:0] data, input string tag);
        logic [7:0] rd, exp_rd;
        logic       idle_bits;
        spi_frame(nbits, {rw, addr, data}, 0);
        rd = '0;
        idle_bits = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            idle_bits |= capt[i][1];
            if (i < 16 || !rw) idle_bits |= capt[i][0];
            else rd = {rd[6:0], capt[i][0]};
        end
        chk({tag, "_idle_bits"}, idle_bits, 1'b0);
        if (rw) begin
            exp_rd = (addr < 32) ? m_regs[addr[4:0]] : 8'h00;
            chk(tag, rd, exp_rd);
        end else if (nbits == 24) begin
            if (addr < 32) m_regs[addr[4:0]] = data;
            if (addr == 15'h0014 && data[0]) m_conv = 1;
        end
        chk("conv_mode_after_reg", conv_mode, m_conv);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        logic [23:0]   tx;
        logic [14:0]   a;
        logic [7:0]    d;
        bit            rw;
        model_reset();
        m_under = 0;
        aresetn = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_sdi = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        repeat (5) @(negedge aclk);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_conv_mode", conv_mode, 1'b1);
        chk("rst_sdo", spi_sdo, 2'b00);
        chk("rst_underrun", underrun, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_after_release", s_axis_tready, 1'b1);
        repeat (4) @(negedge aclk);

        // Single known sample, reassembled by the controller
        push(32'd2342);
        conv_frame(16, 24'h0, "conv_2342");
        w = '0;
        for (int i = 0; i < G; i++) w = {w[DW-N-1:0], capt[i]};
        chk("conv_2342_word", w, 32'd2342);

        // Empty buffer: underrun pulses and previous word repeats
        conv_frame(16, 24'h0, "underrun_a");
        conv_frame(16, 24'h0, "underrun_b");

        // Long frame wraps the lane groups
        push($urandom);
        conv_frame(40, 24'h0, "conv_wrap40");

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) push($urandom);
            tx = 24'($urandom);
            if (tx[23:16] == 8'hA0) tx[16] = 1'b1;
            conv_frame($urandom_range(8, 40), tx, "conv_rand");
        end

        // Register mode entry, write, readback
        conv_frame(24, 24'hA00000, "conv_entry");
        reg_frame(24, 1'b0, 15'h0003, 8'h5A, "wr_3");
        reg_frame(24, 1'b1, 15'h0003, 8'h00, "rd_3");
        reg_frame(20, 1'b0, 15'h0003, 8'h77, "short_wr_3");
        reg_frame(24, 1'b1, 15'h0003, 8'h00, "rd_3_after_short");
        reg_frame(24, 1'b0, 15'h0025, 8'hEE, "wr_oob");
        reg_frame(24, 1'b1, 15'h0025, 8'h00, "rd_oob");
        reg_frame(24, 1'b0, 15'h001F, 8'hC3, "wr_last");
        reg_frame(24, 1'b1, 15'h001F, 8'h00, "rd_last");

        for (int k = 0; k < 14; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 15'($urandom_range(0, 40));
            d  = 8'($urandom);
            if (!rw && a == 15'h0014) d[0] = 1'b0;
            reg_frame(24, rw, a, d, rw ? "rd_rand" : "wr_rand");
        end

        // Exit to conversion mode, then data streams again
        reg_frame(24, 1'b0, 15'h0014, 8'h01, "wr_exit");
        push($urandom);
        conv_frame(16, 24'h0, "conv_after_exit");

        // Reset in the middle of a register write
        conv_frame(24, 24'hA00000, "conv_entry2");
        reg_frame(24, 1'b0, 15'h0007, 8'h33, "wr_7");
        spi_frame(10, {1'b0, 15'h0007, 8'h99}, 1);
        model_reset();
        chk("midrst_conv_mode", conv_mode, 1'b1);
        chk("midrst_tready", s_axis_tready, 1'b1);
        conv_frame(16, 24'h0, "conv_after_rst");
        conv_frame(24, 24'hA00000, "conv_entry3");
        reg_frame(24, 1'b1, 15'h0007, 8'h00, "rd_7_after_rst");
        reg_frame(24, 1'b1, 15'h0003, 8'h00, "rd_3_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_adc_spi_responder.md
# exp_adc_spi_responder

Synthesizable SPI responder emulating the external multi-lane ADC that `axis_exp_adc` controls, for loopback bring-up and hardware-in-the-loop checks without a real converter. Conversion samples come from an AXI-Stream slave and are shifted out MSB-first on `NUM_SDI` parallel lanes. The block also implements the 24-bit register-access protocol: mode entry, byte reads and writes, and exit. All SPI pins are oversampled in the `aclk` domain.

## Interface
- `NUM_SDI`, 2: number of data-out lanes; must divide `DATA_WIDTH`.
- `DATA_WIDTH`, 32: conversion word width.
- `REG_DEPTH`, 32: number of byte registers, addresses 0..`REG_DEPTH`-1.
- `aclk` input 1: system clock. Requires SCK high and low phases of at least 4 `aclk` cycles each.
- `aresetn` input 1: asynchronous active-low reset.
- `spi_sck` input 1: SPI clock from the controller, asynchronous to `aclk`.
- `spi_csn` input 1: chip select, active low, asynchronous.
- `spi_sdi` input 1: controller-to-device serial data.
- `spi_sdo` output `NUM_SDI`: device-to-controller lanes.
- `s_axis_tdata` input `DATA_WIDTH`: next conversion sample.
- `s_axis_tvalid` input 1: sample valid.
- `s_axis_tready` output 1: sample buffer empty.
- `conv_mode` output 1: 1 = conversion mode, 0 = register mode.
- `underrun` output 1: one-cycle pulse when a conversion frame starts with an empty buffer.

## Operation
- Pin sync: `spi_sck`, `spi_csn` and `spi_sdi` each pass through a 2-flop synchronizer. Edge detect on the synchronized `sck`/`csn` produces `sck_rise`, `csn_fall` and `csn_rise`.
- Sample buffer: one entry.
  - `s_axis_tready` = buffer empty.
  - A handshake (`tvalid` and `tready`) loads the buffer.
  - On `csn_fall` in conversion mode:
    - If full, the buffer moves to the shift word and is marked empty.
    - If empty, the previous word is reused and `underrun` pulses.
- Conversion frame:
  - Lane group `k` carries `word[DATA_WIDTH-(k+1)*NUM_SDI +: NUM_SDI]`; `spi_sdo[NUM_SDI-1]` is the more significant bit.
  - Group 0 is driven on `csn_fall`.
  - Each `sck_rise` advances `k`. After group `DATA_WIDTH/NUM_SDI-1`, `k` wraps to 0 and the same word repeats.
  - SDI is shifted in on `sck_rise`. If the first 8 bits equal 8'hA0, the block enters register mode (`conv_mode`=0) at `csn_rise`.
- Register frame: 24 bits MSB-first, fields `{rw[23], addr[22:8], data[7:0]}`, sampled on `sck_rise`.
  - Read (rw=1): `spi_sdo[0]` drives `reg[addr]` MSB-first. Bit 7 is driven after the 16th `sck_rise` and each subsequent bit on the following rises. All other lanes and bits drive 0.
  - Addresses ≥ `REG_DEPTH` read 8'h00.
  - Write (rw=0): commits at `csn_rise` only if exactly 24 bits were received. Otherwise the frame is discarded.
  - A write to 0x0014 with `data[0]`=1 returns to conversion mode. The byte is stored like any other.
  - Writes to addresses ≥ `REG_DEPTH` are dropped, except the exit side effect of 0x0014, which applies regardless of `REG_DEPTH`.
- FSM states:
  - `IDLE`: csn high.
  - `CONV`: a conversion frame is in progress.
  - `REG`: a register frame is in progress.
  - `csn_fall` goes to `CONV` or `REG` according to `conv_mode`.
  - `csn_rise` from any state returns to `IDLE` after applying the mode or write commit. Bit counters clear.
- `csn_rise` mid-frame aborts the frame: no commit, no mode change unless 8'hA0 was already complete. A consumed sample stays consumed.
- Simultaneous AXIS handshake and `csn_fall` consume: the old buffer content goes to the shifter, and the new sample is accepted only after `tready` has been 0 for that cycle.

## Timing
- Pin edge to internal event: 3 `aclk` cycles.
- Pin edge to `spi_sdo` change: 4 `aclk` cycles. The controller samples SDO on the next SCK edge.
- Reset values:
  - `spi_sdo`=0, `conv_mode`=1, `underrun`=0, `s_axis_tready`=0 while reset is asserted, then 1 on the first `aclk` after release.
  - Registers are all 8'h00, the buffer is empty, the previous word is 0.
- Reset asserted mid-frame returns immediately to `IDLE`. Pending writes and the entry command are lost.

## Structure
- Package `exp_adc_pkg` holds:
  - `REG_FRAME_BITS`=24.
  - `REG_ENTRY_CMD`=8'hA0.
  - `REG_EXIT_ADDR`=15'h0014.
  - The FSM state enum `spi_state_t`.
  - The register-frame field positions.
- Sub-module `spi_pin_sync` (generic over pin count): one instance covers sck, csn and sdi. It provides the synchronized levels plus rise and fall strobes.

## Test plan
- Push sample 2342 and run a 16-SCK conversion frame: the controller reassembles 2342 and `s_axis_tready` returns to 1.
- No sample pushed, two frames: `underrun` pulses on each frame and both frames return the last word, or 0 after reset.
- Frame with SDI 8'hA0 then 16 zeros, then write {0, 15'h0003, 8'h5A}, then read {1, 15'h0003, 8'h00}: `spi_sdo[0]` returns 8'h5A in bits 16-23.
- Write with `csn_rise` after 20 bits: register unchanged. Write 8'h01 to 0x0014: `conv_mode`=1 and the next frame returns conversion data.
- Assert reset mid-register-write, then release: `conv_mode`=1 and all registers 8'h00.
- Run 40 SCK cycles in one conversion frame with `NUM_SDI`=2: groups 16-19 repeat groups 0-3.
